// File: rtl/rggen_rtl_pkg.sv
`default_nettype none
// ============================================================================
// rggen_rtl_pkg : shared status/access types and strobe helper
// Revision      : 1.0
// ============================================================================
package rggen_rtl_pkg;

  typedef enum logic [1:0] {
    RGGEN_OKAY   = 2'b00,
    RGGEN_EXOKAY = 2'b01,
    RGGEN_SLVERR = 2'b10,
    RGGEN_DECERR = 2'b11
  } rggen_status;

  typedef enum logic {
    RGGEN_READ  = 1'b0,
    RGGEN_WRITE = 1'b1
  } rggen_access;

  function automatic logic [7:0] rggen_strobe_to_mask(input logic strobe);
    return {8{strobe}};
  endfunction

endpackage
`default_nettype wire

// File: rtl/rggen_wide_write_shadow.sv
`default_nettype none
// ============================================================================
// rggen_wide_write_shadow : accumulates write beats, commits on the last beat
// Revision                : 1.0
// ============================================================================
module rggen_wide_write_shadow
  import rggen_rtl_pkg::*;
#(
  parameter int BUS_WIDTH  = 32,
  parameter int DATA_WIDTH = 128,
  localparam int BEATS     = DATA_WIDTH / BUS_WIDTH,
  localparam int BEAT_BITS = (BEATS > 1) ? $clog2(BEATS) : 1
)(
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   write_i,
  input  logic [BEAT_BITS-1:0]   beat_i,
  input  logic [BUS_WIDTH-1:0]   data_i,
  input  logic [BUS_WIDTH/8-1:0] strobe_i,
  output logic                   seq_error_o,
  output logic                   commit_o,
  output logic [DATA_WIDTH-1:0]  commit_data_o,
  output logic [DATA_WIDTH-1:0]  commit_mask_o
);

  localparam int STROBE_WIDTH = BUS_WIDTH / 8;

  logic [BEAT_BITS-1:0]  exp_q, exp_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [DATA_WIDTH-1:0] mask_q, mask_d;
  logic                  commit_q, commit_d;
  logic [DATA_WIDTH-1:0] commit_data_q, commit_data_d;
  logic [DATA_WIDTH-1:0] commit_mask_q, commit_mask_d;

  logic [BUS_WIDTH-1:0]  w_lane_mask;
  logic [DATA_WIDTH-1:0] w_slot_mask;
  logic [DATA_WIDTH-1:0] w_slot_data;
  logic [DATA_WIDTH-1:0] w_merged_data;
  logic [DATA_WIDTH-1:0] w_merged_mask;
  logic                  w_last;
  logic                  w_seq_error;

  for (genvar i = 0; i < STROBE_WIDTH; i++) begin : g_lane
    assign w_lane_mask[8*i +: 8] = rggen_strobe_to_mask(strobe_i[i]);
  end

  always_comb begin
    w_slot_mask = '0;
    w_slot_data = '0;
    for (int b = 0; b < BEATS; b++) begin
      if (beat_i == BEAT_BITS'(b)) begin
        w_slot_mask[b*BUS_WIDTH +: BUS_WIDTH] = w_lane_mask;
        w_slot_data[b*BUS_WIDTH +: BUS_WIDTH] = data_i & w_lane_mask;
      end
    end
    // Beat 0 restarts the sequence, so it merges onto an empty shadow.
    if (beat_i == '0) begin
      w_merged_data = w_slot_data;
      w_merged_mask = w_slot_mask;
    end else begin
      w_merged_data = (data_q & ~w_slot_mask) | w_slot_data;
      w_merged_mask = mask_q | w_slot_mask;
    end
    w_last      = (beat_i == BEAT_BITS'(BEATS - 1));
    w_seq_error = (beat_i != '0) && (beat_i != exp_q);
  end

  always_comb begin
    exp_d         = exp_q;
    data_d        = data_q;
    mask_d        = mask_q;
    commit_d      = 1'b0;
    commit_data_d = '0;
    commit_mask_d = '0;
    if (write_i) begin
      if (w_seq_error) begin
        exp_d  = '0;
        data_d = '0;
        mask_d = '0;
      end else if (w_last) begin
        commit_d      = 1'b1;
        commit_data_d = w_merged_data;
        commit_mask_d = w_merged_mask;
        exp_d         = '0;
        data_d        = '0;
        mask_d        = '0;
      end else begin
        exp_d  = beat_i + BEAT_BITS'(1);
        data_d = w_merged_data;
        mask_d = w_merged_mask;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      exp_q         <= '0;
      data_q        <= '0;
      mask_q        <= '0;
      commit_q      <= 1'b0;
      commit_data_q <= '0;
      commit_mask_q <= '0;
    end else begin
      exp_q         <= exp_d;
      data_q        <= data_d;
      mask_q        <= mask_d;
      commit_q      <= commit_d;
      commit_data_q <= commit_data_d;
      commit_mask_q <= commit_mask_d;
    end
  end

  assign seq_error_o   = w_seq_error;
  assign commit_o      = commit_q;
  assign commit_data_o = commit_data_q;
  assign commit_mask_o = commit_mask_q;

endmodule
`default_nettype wire

// File: rtl/rggen_wide_shadow_register.sv
`default_nettype none
// ============================================================================
// rggen_wide_shadow_register : multi-beat register with atomic write/read
// Revision                   : 1.0
// ============================================================================
module rggen_wide_shadow_register
  import rggen_rtl_pkg::*;
#(
  parameter bit                     READABLE       = 1'b1,
  parameter bit                     WRITABLE       = 1'b1,
  parameter int                     ADDRESS_WIDTH  = 8,
  parameter logic [ADDRESS_WIDTH-1:0] OFFSET_ADDRESS = '0,
  parameter int                     BUS_WIDTH      = 32,
  parameter int                     DATA_WIDTH     = 128
)(
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_valid,
  input  logic                     i_write,
  input  logic [ADDRESS_WIDTH-1:0] i_address,
  input  logic [BUS_WIDTH-1:0]     i_write_data,
  input  logic [BUS_WIDTH/8-1:0]   i_strobe,
  output logic                     o_match,
  output logic                     o_ready,
  output logic [1:0]               o_status,
  output logic [BUS_WIDTH-1:0]     o_read_data,
  output logic                     o_bf_write_valid,
  output logic [DATA_WIDTH-1:0]    o_bf_write_mask,
  output logic [DATA_WIDTH-1:0]    o_bf_write_data,
  output logic                     o_bf_read_valid,
  input  logic [DATA_WIDTH-1:0]    i_bf_read_data
);

  localparam int BEATS      = DATA_WIDTH / BUS_WIDTH;
  localparam int BEAT_BITS  = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int BYTE_SHIFT = $clog2(BUS_WIDTH / 8);
  localparam logic [ADDRESS_WIDTH:0] RANGE_BYTES =
    (ADDRESS_WIDTH + 1)'(BEATS * BUS_WIDTH / 8);
  localparam logic [ADDRESS_WIDTH:0] START_ADDRESS = {1'b0, OFFSET_ADDRESS};
  localparam logic [ADDRESS_WIDTH:0] END_ADDRESS   = START_ADDRESS + RANGE_BYTES;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RESP = 1'b1;

  logic [0:0]            state_q, state_d;
  rggen_status           status_q, status_d;
  logic [BUS_WIDTH-1:0]  read_data_q, read_data_d;
  logic                  read_valid_q, read_valid_d;
  logic [DATA_WIDTH-1:0] snapshot_q, snapshot_d;

  logic [ADDRESS_WIDTH-1:0] w_rel_address;
  logic [BEAT_BITS-1:0]     w_beat;
  rggen_access              w_access;
  logic                     w_accept;
  logic                     w_access_error;
  logic                     w_shadow_write;
  logic                     w_read;
  logic                     w_seq_error;

  // Widened by one bit so the range end cannot wrap at the top of the map.
  assign o_match       = ({1'b0, i_address} >= START_ADDRESS) &&
                         ({1'b0, i_address} <  END_ADDRESS);
  assign w_rel_address = i_address - OFFSET_ADDRESS;
  assign w_beat        = BEAT_BITS'(w_rel_address >> BYTE_SHIFT);

  assign w_access       = rggen_access'(i_write);
  assign w_accept       = (state_q == ST_IDLE) && i_valid && o_match;
  assign w_access_error = (w_access == RGGEN_WRITE) ? !WRITABLE : !READABLE;
  assign w_shadow_write = w_accept && (w_access == RGGEN_WRITE) && !w_access_error;
  assign w_read         = w_accept && (w_access == RGGEN_READ) && !w_access_error;

  rggen_wide_write_shadow #(
    .BUS_WIDTH  (BUS_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_write_shadow (
    .clk_i         (i_clk),
    .rst_i         (i_rst),
    .write_i       (w_shadow_write),
    .beat_i        (w_beat),
    .data_i        (i_write_data),
    .strobe_i      (i_strobe),
    .seq_error_o   (w_seq_error),
    .commit_o      (o_bf_write_valid),
    .commit_data_o (o_bf_write_data),
    .commit_mask_o (o_bf_write_mask)
  );

  always_comb begin
    state_d      = w_accept ? ST_RESP : ST_IDLE;
    status_d     = RGGEN_OKAY;
    read_data_d  = '0;
    read_valid_d = 1'b0;
    snapshot_d   = snapshot_q;
    if (w_accept && (w_access_error || (w_shadow_write && w_seq_error))) begin
      status_d = RGGEN_SLVERR;
    end
    // Beat 0 captures the whole field so later beats read one coherent value.
    if (w_read) begin
      if (w_beat == '0) begin
        snapshot_d   = i_bf_read_data;
        read_data_d  = i_bf_read_data[BUS_WIDTH-1:0];
        read_valid_d = 1'b1;
      end else begin
        read_data_d  = snapshot_q[int'(w_beat)*BUS_WIDTH +: BUS_WIDTH];
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q      <= ST_IDLE;
      status_q     <= RGGEN_OKAY;
      read_data_q  <= '0;
      read_valid_q <= 1'b0;
      snapshot_q   <= '0;
    end else begin
      state_q      <= state_d;
      status_q     <= status_d;
      read_data_q  <= read_data_d;
      read_valid_q <= read_valid_d;
      snapshot_q   <= snapshot_d;
    end
  end

  assign o_ready         = (state_q == ST_RESP);
  assign o_status        = status_q;
  assign o_read_data     = read_data_q;
  assign o_bf_read_valid = read_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_rggen_wide_shadow_register.sv
`default_nettype none
// ============================================================================
// tb_rggen_wide_shadow_register : scoreboard bench, 3-beat 96-bit register
// Revision                      : 1.0
// ============================================================================
module tb_rggen_wide_shadow_register;

  localparam int AW = 8;
  localparam int BW = 32;
  localparam int DW = 96;

  localparam logic [1:0] OK  = 2'b00;
  localparam logic [1:0] ERR = 2'b10;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_valid;
  logic          i_write;
  logic [AW-1:0] i_address;
  logic [BW-1:0] i_write_data;
  logic [BW/8-1:0] i_strobe;
  logic          o_match;
  logic          o_ready;
  logic [1:0]    o_status;
  logic [BW-1:0] o_read_data;
  logic          o_bf_write_valid;
  logic [DW-1:0] o_bf_write_mask;
  logic [DW-1:0] o_bf_write_data;
  logic          o_bf_read_valid;
  logic [DW-1:0] i_bf_read_data;

  typedef struct {
    logic [1:0]    status;
    logic [BW-1:0] rdata;
    logic          wvalid;
    logic [DW-1:0] wdata;
    logic [DW-1:0] wmask;
    logic          rvalid;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  rggen_wide_shadow_register #(
    .READABLE       (1'b1),
    .WRITABLE       (1'b1),
    .ADDRESS_WIDTH  (AW),
    .OFFSET_ADDRESS (8'h10),
    .BUS_WIDTH      (BW),
    .DATA_WIDTH     (DW)
  ) dut (
    .i_clk            (clk),
    .i_rst            (rst),
    .i_valid          (i_valid),
    .i_write          (i_write),
    .i_address        (i_address),
    .i_write_data     (i_write_data),
    .i_strobe         (i_strobe),
    .o_match          (o_match),
    .o_ready          (o_ready),
    .o_status         (o_status),
    .o_read_data      (o_read_data),
    .o_bf_write_valid (o_bf_write_valid),
    .o_bf_write_mask  (o_bf_write_mask),
    .o_bf_write_data  (o_bf_write_data),
    .o_bf_read_valid  (o_bf_read_valid),
    .i_bf_read_data   (i_bf_read_data)
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: compares each response against the oldest expectation.
  always @(negedge clk) begin
    if (o_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_ready", 1'b1, 1'b0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("status",   o_status,         e.status);
        check("rdata",    o_read_data,      e.rdata);
        check("wvalid",   o_bf_write_valid, e.wvalid);
        check("wdata",    o_bf_write_data,  e.wdata);
        check("wmask",    o_bf_write_mask,  e.wmask);
        check("rvalid",   o_bf_read_valid,  e.rvalid);
      end
    end else begin
      check("idle_side_outputs",
            {o_bf_write_valid, o_bf_read_valid, o_bf_write_data, o_bf_write_mask},
            '0);
    end
  end

  task automatic issue(input logic wr, input logic [AW-1:0] addr, input logic [BW-1:0] wd,
                       input logic [BW/8-1:0] st, input logic [1:0] es, input logic [BW-1:0] erd,
                       input logic ewv, input logic [DW-1:0] ewd, input logic [DW-1:0] ewm,
                       input logic erv);
    exp_t e;
    e.status = es; e.rdata = erd; e.wvalid = ewv;
    e.wdata  = ewd; e.wmask = ewm; e.rvalid = erv;
    sb.push_back(e);
    @(posedge clk); #1;
    i_valid = 1'b1; i_write = wr; i_address = addr; i_write_data = wd; i_strobe = st;
    #1 check("match_on_request", o_match, 1'b1);
    @(posedge clk); #1;
    i_valid = 1'b0;
  endtask

  task automatic wr(input logic [AW-1:0] addr, input logic [BW-1:0] wd, input logic [3:0] st,
                    input logic [1:0] es, input logic ewv, input logic [DW-1:0] ewd,
                    input logic [DW-1:0] ewm);
    issue(1'b1, addr, wd, st, es, '0, ewv, ewd, ewm, 1'b0);
  endtask

  task automatic rd(input logic [AW-1:0] addr, input logic [BW-1:0] erd, input logic erv);
    issue(1'b0, addr, '0, '0, OK, erd, 1'b0, '0, '0, erv);
  endtask

  task automatic probe_match(input logic [AW-1:0] addr, input logic exp);
    i_address = addr;
    #1 check($sformatf("match_%0h", addr), o_match, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; i_valid = 1'b0; i_write = 1'b0; i_address = '0;
    i_write_data = '0; i_strobe = '0; i_bf_read_data = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_ready",  o_ready,     1'b0);
    check("reset_status", o_status,    OK);
    check("reset_rdata",  o_read_data, '0);
    rst = 1'b0;

    probe_match(8'h0F, 1'b0);
    probe_match(8'h10, 1'b1);
    probe_match(8'h1B, 1'b1);
    probe_match(8'h1C, 1'b0);

    // Out-of-order first beat after reset
    wr(8'h14, 32'h22222222, 4'hF, ERR, 1'b0, '0, '0);

    // Full sequence
    wr(8'h10, 32'h11111111, 4'hF, OK, 1'b0, '0, '0);
    wr(8'h14, 32'h22222222, 4'hF, OK, 1'b0, '0, '0);
    wr(8'h18, 32'h33333333, 4'hF, OK, 1'b1,
       96'h33333333_22222222_11111111, {96{1'b1}});

    // Skipped beat aborts the sequence
    wr(8'h10, 32'h11111111, 4'hF, OK,  1'b0, '0, '0);
    wr(8'h18, 32'h33333333, 4'hF, ERR, 1'b0, '0, '0);
    wr(8'h14, 32'h22222222, 4'hF, ERR, 1'b0, '0, '0);

    // Partial strobe on beat 1
    wr(8'h10, 32'h11111111, 4'hF,     OK, 1'b0, '0, '0);
    wr(8'h14, 32'h22222222, 4'b0011,  OK, 1'b0, '0, '0);
    wr(8'h18, 32'h33333333, 4'hF,     OK, 1'b1,
       96'h33333333_00002222_11111111, 96'hFFFFFFFF_0000FFFF_FFFFFFFF);

    // Zero strobe still advances
    wr(8'h10, 32'hDEADBEEF, 4'hF, OK, 1'b0, '0, '0);
    wr(8'h14, 32'hCAFEF00D, 4'h0, OK, 1'b0, '0, '0);
    wr(8'h18, 32'h01020304, 4'hF, OK, 1'b1,
       96'h01020304_00000000_DEADBEEF, 96'hFFFFFFFF_00000000_FFFFFFFF);

    // Snapshot read
    i_bf_read_data = 96'hAAAAAAAA_BBBBBBBB_CCCCCCCC;
    rd(8'h10, 32'hCCCCCCCC, 1'b1);
    i_bf_read_data = {96{1'b1}};
    rd(8'h18, 32'hAAAAAAAA, 1'b0);

    // Read in the middle of a write sequence; unaligned addresses
    wr(8'h10, 32'h55555555, 4'hF, OK, 1'b0, '0, '0);
    rd(8'h16, 32'hBBBBBBBB, 1'b0);
    wr(8'h14, 32'h66666666, 4'hF, OK, 1'b0, '0, '0);
    wr(8'h19, 32'h77777777, 4'hF, OK, 1'b1,
       96'h77777777_66666666_55555555, {96{1'b1}});

    // Non-matching request yields no response
    @(posedge clk); #1;
    i_valid = 1'b1; i_write = 1'b1; i_address = 8'h20;
    #1 check("nomatch", o_match, 1'b0);
    repeat (2) @(posedge clk);
    #1 i_valid = 1'b0;

    // Reset mid-sequence discards the shadow
    wr(8'h10, 32'h11111111, 4'hF, OK, 1'b0, '0, '0);
    wr(8'h14, 32'h22222222, 4'hF, OK, 1'b0, '0, '0);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    wr(8'h18, 32'h33333333, 4'hF, ERR, 1'b0, '0, '0);

    repeat (3) @(posedge clk);
    check("scoreboard_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/rggen_wide_shadow_register.md
Name: rggen_wide_shadow_register

Overview:
- Register endpoint for fields wider than the CPU bus (DATA_WIDTH = BEATS*BUS_WIDTH), accessed as BEATS consecutive bus words.
- Provides atomic multi-beat access. Writes accumulate in a shadow buffer and commit to the bit fields in a single cycle on the last beat. Reads snapshot the full value on beat 0.
- Sits between the register-map decode fabric and the bit-field logic, in place of a single-beat register.

Parameters:
- READABLE, 1, register supports read access.
- WRITABLE, 1, register supports write access.
- ADDRESS_WIDTH, 8, bus address width.
- OFFSET_ADDRESS, '0, byte address of beat 0; must be BUS_WIDTH/8 aligned.
- BUS_WIDTH, 32, bus data width, power of 2 and >= 8.
- DATA_WIDTH, 128, total register width; must be a multiple of BUS_WIDTH.
- BEATS (localparam), DATA_WIDTH/BUS_WIDTH.
- BEAT_BITS (localparam), max(1, clog2(BEATS)).

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  synchronous reset, active-high.
- i_valid  in  1  request valid; held until o_ready.
- i_write  in  1  1 = write, 0 = read.
- i_address  in  ADDRESS_WIDTH  byte address.
- i_write_data  in  BUS_WIDTH  write data.
- i_strobe  in  BUS_WIDTH/8  byte enables.
- o_match  out  1  combinational address hit.
- o_ready  out  1  one-cycle response pulse.
- o_status  out  2  response status: OKAY=2'b00, SLVERR=2'b10.
- o_read_data  out  BUS_WIDTH  read data, valid with o_ready.
- o_bf_write_valid  out  1  commit pulse to the bit fields.
- o_bf_write_mask  out  DATA_WIDTH  bit mask, expanded from the byte strobes.
- o_bf_write_data  out  DATA_WIDTH  committed data.
- o_bf_read_valid  out  1  read-side-effect pulse on beat-0 read.
- i_bf_read_data  in  DATA_WIDTH  current field value.

Behaviour:
- Match and beat index:
  - o_match is asserted when OFFSET_ADDRESS <= i_address < OFFSET_ADDRESS + BEATS*BUS_WIDTH/8.
  - beat = (i_address - OFFSET_ADDRESS) >> clog2(BUS_WIDTH/8). Address bits below the word boundary are ignored.
- Handshake and FSM (IDLE -> RESP -> IDLE):
  - A request is accepted in IDLE when i_valid & o_match.
  - o_ready pulses in the following cycle, so latency is 1 cycle.
  - While in RESP the block accepts nothing, so one request is outstanding at most.
  - The cycle after RESP is IDLE. A master that still holds i_valid is treated as issuing a new request.
  - Non-matching requests produce no response.
- Access errors:
  - A write when WRITABLE=0, or a read when READABLE=0, returns SLVERR.
  - An erroring access changes no state, and its read data is 0.
- Write sequence:
  - Registers: expected beat counter exp (BEAT_BITS wide), shadow data, shadow mask.
  - A write to beat 0 always restarts the sequence: the shadow is cleared, beat 0 is stored, and exp becomes 1.
  - A write to beat k == exp (k > 0) stores bytes where i_strobe=1 into shadow data and mask, then increments exp.
  - A write to beat k != exp (k > 0) returns SLVERR, clears the shadow and sets exp to 0.
  - When the stored beat is BEATS-1:
    - o_bf_write_valid pulses for one cycle, coincident with o_ready.
    - o_bf_write_data and o_bf_write_mask carry the full shadow, including the final beat.
    - exp then returns to 0 and the shadow is cleared.
  - BEATS=1: every write commits directly and the sequence check is disabled.
  - Strobe all-zero on a beat still advances exp and returns OKAY.
- Read sequence:
  - A read of beat 0 pulses o_bf_read_valid and captures i_bf_read_data into the read snapshot. o_read_data returns the beat-0 slice of that value.
  - A read of beat k > 0 returns snapshot slice k, with no side effect.
  - Reads do not disturb an in-progress write sequence.
- Reset values:
  - o_ready, o_bf_write_valid, o_bf_read_valid = 0.
  - o_status = OKAY.
  - o_read_data, o_bf_write_data, o_bf_write_mask = 0.
  - Snapshot and shadow = 0; exp = 0; FSM = IDLE.
- Precedence:
  - Reset overrides everything, including mid-sequence and during RESP.
  - A pending response is dropped and no commit occurs.
- o_bf_write_data and o_bf_write_mask are 0 whenever o_bf_write_valid is 0.

Decomposition:
- rggen_rtl_pkg holds:
  - rggen_status enum (OKAY, EXOKAY, SLVERR, DECERR).
  - rggen_access enum.
  - function expanding a byte strobe into a bit mask.
- Sub-module rggen_wide_write_shadow holds exp, the shadow data/mask, the sequence check and the commit pulse. The top level holds decode, the FSM and the read snapshot.

Test Plan:
All scenarios use BUS_WIDTH=32, DATA_WIDTH=96, OFFSET_ADDRESS=0x10.
- Reset asserted 3 cycles -> all outputs 0, o_status=OKAY; first write to 0x14 afterwards returns SLVERR.
- Writes 0x10=0x11111111, 0x14=0x22222222, 0x18=0x33333333 with strobe 4'hF -> o_ready 1 cycle after each request, all OKAY; single o_bf_write_valid pulse with the third response, data=0x333333332222222211111111, mask all ones.
- Write 0x10, then 0x18 -> second write returns SLVERR, no commit; a following 0x14 write also returns SLVERR (exp=0).
- Writes with beat-1 strobe 4'b0011 -> committed mask = 0xFFFFFFFF_0000FFFF_FFFFFFFF.
- Read 0x10 with i_bf_read_data=0xA_B_C (per word), then change the input to all 0xF, then read 0x18 -> o_read_data=0xA word, one o_bf_read_valid pulse total.
- Write 0x10 and 0x14, assert i_rst for 1 cycle, then write 0x18 -> SLVERR, no o_bf_write_valid.
